// File: rtl/display_pkg.sv
// ------------------------------------------------------------------------
// display_pkg: shared types for the status-digit display path.  Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

package display_pkg;

  localparam int SEG_CODE_W = 3;

  typedef logic [SEG_CODE_W-1:0] seg_code_t;

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_SETTLE = 1'b1
  } dbnc_state_t;

endpackage

`default_nettype wire

// File: rtl/sync_ff.sv
// ------------------------------------------------------------------------
// sync_ff: multi-bit flip-flop synchroniser, cleared by rst_i.  Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module sync_ff #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  // Element 0 is the capture flop; the raw input feeds it with no logic in between.
  logic [STAGES-1:0][WIDTH-1:0] stage_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/switch_code_debouncer.sv
// ------------------------------------------------------------------------
// switch_code_debouncer: synchronise and debounce a switch vector into a
// stable code with valid flag and change pulse.  Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module switch_code_debouncer
  import display_pkg::*;
#(
  parameter int CODE_W          = SEG_CODE_W,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [CODE_W-1:0] switch_i,
  output logic [CODE_W-1:0] code_o,
  output logic              valid_o,
  output logic              changed_o
);

  localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CODE_W-1:0] sync_s;

  dbnc_state_t       state_q;
  logic [CODE_W-1:0] cand_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CODE_W-1:0] code_q;
  logic              valid_q;
  logic              changed_q;
  logic              start_q;

  sync_ff #(
    .WIDTH  (CODE_W),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (switch_i),
    .q_o   (sync_s)
  );

  // start_q forces one full window right after reset so even a 0 input gets committed.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_STABLE;
      cand_q    <= '0;
      cnt_q     <= '0;
      code_q    <= '0;
      valid_q   <= 1'b0;
      changed_q <= 1'b0;
      start_q   <= 1'b1;
    end else begin
      changed_q <= 1'b0;
      start_q   <= 1'b0;
      if (start_q) begin
        cand_q  <= sync_s;
        cnt_q   <= '0;
        state_q <= ST_SETTLE;
      end else begin
        case (state_q)
          ST_STABLE: begin
            if (sync_s != cand_q) begin
              cand_q  <= sync_s;
              cnt_q   <= '0;
              state_q <= ST_SETTLE;
            end
          end
          ST_SETTLE: begin
            if (sync_s != cand_q) begin
              cand_q <= sync_s;
              cnt_q  <= '0;
            end else if (cnt_q < CNT_MAX) begin
              cnt_q <= cnt_q + 1'b1;
            end else begin
              code_q    <= cand_q;
              valid_q   <= 1'b1;
              changed_q <= (cand_q != code_q);
              state_q   <= ST_STABLE;
            end
          end
          default: state_q <= ST_STABLE;
        endcase
      end
    end
  end

  assign code_o    = code_q;
  assign valid_o   = valid_q;
  assign changed_o = changed_q;

endmodule

`default_nettype wire

// File: tb/tb_switch_code_debouncer.sv
// ------------------------------------------------------------------------
// tb_switch_code_debouncer: scoreboard bench for switch_code_debouncer.
// Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module tb_switch_code_debouncer;
  import display_pkg::*;

  localparam int SYNC = 2;
  localparam int DB   = 4;
  localparam int LAT  = SYNC + 1 + DB;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [2:0] switch_i;
  logic [2:0] code_o;
  logic       valid_o;
  logic       changed_o;

  switch_code_debouncer #(
    .CODE_W          (3),
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .switch_i  (switch_i),
    .code_o    (code_o),
    .valid_o   (valid_o),
    .changed_o (changed_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int         cyc;
    logic [2:0] code;
    logic       valid;
    logic       chg;
    string      tag;
  } exp_t;

  exp_t       sb_q[$];
  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  logic [2:0] m_code  = 3'b000;
  logic       m_valid = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic [2:0] code, input logic valid,
                      input logic chg, input string tag);
    exp_t e;
    e.cyc = c; e.code = code; e.valid = valid; e.chg = chg; e.tag = tag;
    sb_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  always @(posedge clk_i) cyc <= cyc + 1;

  // Scheduled entries are checked on their edge; every other cycle must hold.
  always @(negedge clk_i) begin : monitor
    exp_t e;
    if (cyc > 0) begin
      while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
        e = sb_q.pop_front();
        chk({e.tag, ".stale"}, cyc, e.cyc);
      end
      if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
        e = sb_q.pop_front();
        chk({e.tag, ".code"}, code_o, e.code);
        chk({e.tag, ".valid"}, valid_o, e.valid);
        chk({e.tag, ".changed"}, changed_o, e.chg);
        m_code  = e.code;
        m_valid = e.valid;
      end else begin
        chk("hold.code", code_o, m_code);
        chk("hold.valid", valid_o, m_valid);
        chk("idle.changed", changed_o, 1'b0);
      end
    end
  end

  initial begin
    int k;
    int last;
    rst_i    = 1'b1;
    switch_i = 3'b101;
    push(1, 3'b000, 1'b0, 1'b0, "rst1");
    push(2, 3'b000, 1'b0, 1'b0, "rst2");
    push(3, 3'b000, 1'b0, 1'b0, "rst3");
    step(3);

    // First commit of a zero input after release.
    rst_i    = 1'b0;
    switch_i = 3'b000;
    k = cyc;
    push(k + 1 + DB, 3'b000, 1'b1, 1'b0, "first");
    step(8);

    k = cyc;
    switch_i = 3'b011;
    push(k + LAT, 3'b011, 1'b1, 1'b1, "clean");
    step(LAT + 3);

    last = cyc;
    for (int i = 0; i < 5; i++) begin
      switch_i = (i % 2 == 0) ? 3'b111 : 3'b011;
      last = cyc;
      step(2);
    end
    push(last + LAT, 3'b111, 1'b1, 1'b1, "bounce");
    step(LAT + 2);

    k = cyc;
    switch_i = 3'b001;
    step(3);
    switch_i = 3'b111;
    step(1);
    chk("glitch.settle", dut.state_q, ST_SETTLE);
    push(k + 10, 3'b111, 1'b1, 1'b0, "glitch");
    step(6);
    chk("glitch.stable", dut.state_q, ST_STABLE);
    step(2);

    k = cyc;
    switch_i = 3'b010;
    step(4);
    rst_i = 1'b1;
    push(k + 5, 3'b000, 1'b0, 1'b0, "midrst");
    step(2);
    rst_i = 1'b0;
    push(k + 6 + SYNC + 1 + DB, 3'b010, 1'b1, 1'b1, "postrst");
    step(10);

    for (int n = 0; n < 50 && sb_q.size() > 0; n++) step(1);
    chk("pending", sb_q.size(), 0);
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
